// File: rtl/data_arb_pkg.sv
// data_arb_pkg: shared types and widths for the data memory arbiter.
package data_arb_pkg;
  typedef enum logic [1:0] {IDLE, CORE_DONE, DMA_DONE} arb_state_e;
  typedef enum logic {OWNER_CORE, OWNER_DMA} owner_e;
  localparam int CNT_W = 32;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin picker; bit0 = core, bit1 = DMA, one-hot grant.
module rr_arb2
  import data_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_owner_i,
  output logic [1:0] gnt_o
);
  always_comb gnt_o = (&req_i) ? ((last_owner_i == OWNER_CORE) ? 2'b10 : 2'b01) : req_i;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one synchronous-read data memory between the core and a DMA port.
// Define DATA_MEM_ARB_STAT_EN to build the saturating contention counter.
module data_mem_arbiter
  import data_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [ADDR_W-1:0]   core_addr_i,
  input  logic [DATA_W-1:0]   core_wd_i,
  input  logic [DATA_W/8-1:0] core_be_i,
  output logic                core_stall_o,
  output logic [DATA_W-1:0]   core_rd_o,
  input  logic                dma_req_i,
  input  logic                dma_we_i,
  input  logic [ADDR_W-1:0]   dma_addr_i,
  input  logic [DATA_W-1:0]   dma_wd_i,
  input  logic [DATA_W/8-1:0] dma_be_i,
  output logic                dma_gnt_o,
  output logic                dma_rvalid_o,
  output logic [DATA_W-1:0]   dma_rd_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wd_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rd_i,
  output logic [CNT_W-1:0]    conflict_cnt_o
);
  arb_state_e r_state, w_next;
  owner_e     r_last_owner;
  logic [1:0] w_gnt;
  logic       w_idle, w_core_win, w_dma_win;

  rr_arb2 u_rr (
    .req_i        ({dma_req_i, core_req_i}),
    .last_owner_i (r_last_owner),
    .gnt_o        (w_gnt)
  );

  assign w_idle     = (r_state == IDLE);
  assign w_core_win = w_idle && w_gnt[0];
  assign w_dma_win  = w_idle && w_gnt[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_last_owner <= OWNER_DMA;
    end else begin
      r_state <= w_next;
      if (w_core_win) r_last_owner <= OWNER_CORE;
      else if (w_dma_win) r_last_owner <= OWNER_DMA;
    end
  end

  always_comb w_next = !w_idle ? IDLE : w_core_win ? CORE_DONE : w_dma_win ? DMA_DONE : IDLE;

  // Reset suppresses any issue so a stale IDLE decision never reaches memory.
  always_comb begin
    mem_req_o    = !rst_i && (w_core_win || w_dma_win);
    mem_we_o     = mem_req_o && (w_core_win ? core_we_i : dma_we_i);
    mem_addr_o   = !mem_req_o ? '0 : w_core_win ? core_addr_i : dma_addr_i;
    mem_wd_o     = !mem_req_o ? '0 : w_core_win ? core_wd_i : dma_wd_i;
    mem_be_o     = !mem_req_o ? '0 : w_core_win ? core_be_i : dma_be_i;
    dma_gnt_o    = !rst_i && w_dma_win;
    dma_rvalid_o = !rst_i && (r_state == DMA_DONE);
    core_stall_o = core_req_i && (rst_i || r_state != CORE_DONE);
    core_rd_o    = mem_rd_i;
    dma_rd_o     = mem_rd_i;
  end

`ifdef DATA_MEM_ARB_STAT_EN
  logic [CNT_W-1:0] r_conflict_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_conflict_cnt <= '0;
    else if (w_idle && core_req_i && dma_req_i && !(&r_conflict_cnt)) r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
  end
  assign conflict_cnt_o = r_conflict_cnt;
`else
  assign conflict_cnt_o = '0;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of arbitration, latency, reset and the contention counter.
module tb_data_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        core_req = 0, core_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] core_addr = 0, core_wd = 0, dma_addr = 0, dma_wd = 0;
  logic [3:0]  core_be = 0, dma_be = 0;
  logic        core_stall, dma_gnt, dma_rvalid, mem_req, mem_we;
  logic [31:0] core_rd, dma_rd, mem_addr, mem_wd, mem_rd, conflict_cnt;
  logic [3:0]  mem_be;
  logic [31:0] mem [0:63];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wd_i(core_wd), .core_be_i(core_be),
    .core_stall_o(core_stall), .core_rd_o(core_rd),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wd_i(dma_wd), .dma_be_i(dma_be),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rd_o(dma_rd),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_be_o(mem_be),
    .mem_rd_i(mem_rd), .conflict_cnt_o(conflict_cnt)
  );

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
  end

  // Synchronous-read memory: data appears the cycle after the request.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end else mem_rd <= mem[mem_addr[7:2]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; core_req = 0; dma_req = 0;
    step(); step(); #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_tests++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_dma_gnt got %b exp 0", dma_gnt); end
    n_tests++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b exp 0", dma_rvalid); end
    n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle got %b exp 0", core_stall); end
    n_tests++; if (conflict_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", conflict_cnt); end
    core_req = 1; dma_req = 1; #1;
    n_tests++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_follow got %b exp 1", core_stall); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_busy got %b exp 0", mem_req); end
    n_tests++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_busy got %b exp 0", dma_gnt); end
    core_req = 0; dma_req = 0;
    step(); rst = 0;
  endtask

  task automatic test_core_load();
    core_req = 1; core_we = 0; core_addr = 32'h10; #1;
    n_tests++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL load_stall0 got %b exp 1", core_stall); end
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL load_mem_req0 got %b exp 1", mem_req); end
    n_tests++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL load_mem_addr got %h exp 10", mem_addr); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL load_mem_we got %b exp 0", mem_we); end
    n_tests++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL load_gnt got %b exp 0", dma_gnt); end
    step();
    n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL load_stall1 got %b exp 0", core_stall); end
    n_tests++; if (core_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rd got %h exp deadbeef", core_rd); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL load_mem_req1 got %b exp 0", mem_req); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL load_addr_idle got %h exp 0", mem_addr); end
    core_req = 0;
    step();
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wd = 32'h12345678; dma_be = 4'hF; #1;
    n_tests++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dmaw_gnt got %b exp 1", dma_gnt); end
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL dmaw_we got %b exp 1", mem_we); end
    n_tests++; if (mem_addr !== 32'h20) begin n_fail++; $display("FAIL dmaw_addr got %h exp 20", mem_addr); end
    n_tests++; if (mem_wd !== 32'h12345678) begin n_fail++; $display("FAIL dmaw_wd got %h exp 12345678", mem_wd); end
    n_tests++; if (mem_be !== 4'hF) begin n_fail++; $display("FAIL dmaw_be got %h exp f", mem_be); end
    n_tests++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dmaw_rvalid0 got %b exp 0", dma_rvalid); end
    step(); dma_req = 0; dma_we = 0; #1;
    n_tests++; if (dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL dmaw_rvalid1 got %b exp 1", dma_rvalid); end
    n_tests++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL dmaw_gnt1 got %b exp 0", dma_gnt); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL dmaw_mem_req1 got %b exp 0", mem_req); end
    step();
    n_tests++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dmaw_rvalid2 got %b exp 0", dma_rvalid); end
    core_req = 1; core_addr = 32'h20; #1;
    step();
    n_tests++; if (core_rd !== 32'h12345678) begin n_fail++; $display("FAIL dmaw_readback got %h exp 12345678", core_rd); end
    core_req = 0;
    step();
  endtask

  task automatic test_simultaneous();
    rst = 1; step(); rst = 0;
    core_req = 1; core_addr = 32'h10; dma_req = 1; dma_we = 0; dma_addr = 32'h20; #1;
    n_tests++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL sim_gnt0 got %b exp 0", dma_gnt); end
    n_tests++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL sim_stall0 got %b exp 1", core_stall); end
    n_tests++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL sim_addr0 got %h exp 10", mem_addr); end
    step();
    n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL sim_stall1 got %b exp 0", core_stall); end
    n_tests++; if (core_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sim_core_rd got %h exp deadbeef", core_rd); end
    n_tests++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL sim_gnt1 got %b exp 0", dma_gnt); end
    step(); core_req = 0; #1;
    n_tests++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL sim_gnt2 got %b exp 1", dma_gnt); end
    n_tests++; if (mem_addr !== 32'h20) begin n_fail++; $display("FAIL sim_addr2 got %h exp 20", mem_addr); end
    step(); dma_req = 0; #1;
    n_tests++; if (dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL sim_rvalid3 got %b exp 1", dma_rvalid); end
    n_tests++; if (dma_rd !== 32'h12345678) begin n_fail++; $display("FAIL sim_dma_rd got %h exp 12345678", dma_rd); end
    step();
  endtask

  task automatic test_back_to_back();
    int wait_cyc = 0, core_gnts = 0, dma_gnts = 0;
    logic exp_dma = 1'b0;
    core_req = 1; core_addr = 32'h10; dma_req = 1; dma_addr = 32'h20; #1;
    for (int c = 0; c < 32; c++) begin
      if (c % 2 == 0) begin
        n_tests++; if (mem_req !== 1'b1 || dma_gnt !== exp_dma) begin n_fail++; $display("FAIL b2b_grant c=%0d got req=%b gnt=%b exp req=1 gnt=%b", c, mem_req, dma_gnt, exp_dma); end
        if (dma_gnt) dma_gnts++; else core_gnts++;
        exp_dma = ~exp_dma;
      end
      wait_cyc++;
      if (!core_stall) begin
        n_tests++; if (wait_cyc > 4) begin n_fail++; $display("FAIL b2b_core_wait c=%0d got %0d cycles exp <=4", c, wait_cyc); end
        wait_cyc = 0;
      end
      step();
    end
    n_tests++; if (core_gnts != 8 || dma_gnts != 8) begin n_fail++; $display("FAIL b2b_counts got core=%0d dma=%0d exp 8/8", core_gnts, dma_gnts); end
    core_req = 0; dma_req = 0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    core_req = 1; core_addr = 32'h10; #1;
    step();
    n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_core_done got %b exp 0", core_stall); end
    rst = 1; #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_req got %b exp 0", mem_req); end
    n_tests++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL rmid_stall got %b exp 1", core_stall); end
    step();
    n_tests++; if (mem_req !== 1'b0 || dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_in_reset got req=%b rvalid=%b exp 0/0", mem_req, dma_rvalid); end
    rst = 0; #1;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL rmid_reissue got req=%b addr=%h exp 1/10", mem_req, mem_addr); end
    step();
    n_tests++; if (core_stall !== 1'b0 || core_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rmid_complete got stall=%b rd=%h exp 0/deadbeef", core_stall, core_rd); end
    core_req = 0;
    step();
  endtask

  task automatic test_conflict_cnt();
    logic [31:0] exp_cnt;
`ifdef DATA_MEM_ARB_STAT_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    rst = 1; step(); rst = 0;
    core_req = 1; dma_req = 1; #1;
    for (int c = 0; c < 10; c++) step();
    n_tests++; if (conflict_cnt !== exp_cnt) begin n_fail++; $display("FAIL conflict_cnt got %0d exp %0d", conflict_cnt, exp_cnt); end
    core_req = 0; dma_req = 0;
    step();
    n_tests++; if (conflict_cnt !== exp_cnt) begin n_fail++; $display("FAIL conflict_cnt_hold got %0d exp %0d", conflict_cnt, exp_cnt); end
  endtask

  initial begin
    #1;
    test_reset();
    test_core_load();
    test_dma_write();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_conflict_cnt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single synchronous-read data memory between two requesters: the core's load/store port and a secondary bus master (DMA/debug port).
- Sits between `processor_system`'s core data interface and the data memory instance, and generates the core's `stall_i`.
- With no contention, the core sees exactly today's protocol: stall high in the request cycle, low the next cycle.
- Under contention, stall is extended until the core's access completes.

Parameters:
- ADDR_W, 32, byte-address width of both requesters and the memory port
- DATA_W, 32, data width; byte enables are DATA_W/8 bits

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- core_req_i  in  1  core memory request; held stable until stall_o is low
- core_we_i  in  1  core write enable
- core_addr_i  in  ADDR_W  core address
- core_wd_i  in  DATA_W  core write data
- core_be_i  in  DATA_W/8  core byte enables
- core_stall_o  out  1  stall to core
- core_rd_o  out  DATA_W  read data to core, valid when core_req_i && !core_stall_o
- dma_req_i  in  1  secondary request; held with its fields until dma_gnt_o
- dma_we_i  in  1  secondary write enable
- dma_addr_i  in  ADDR_W  secondary address
- dma_wd_i  in  DATA_W  secondary write data
- dma_be_i  in  DATA_W/8  secondary byte enables
- dma_gnt_o  out  1  access issued to memory this cycle
- dma_rvalid_o  out  1  one-cycle pulse, read data valid
- dma_rd_o  out  DATA_W  secondary read data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wd_o  out  DATA_W  memory write data
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_rd_i  in  DATA_W  memory read data, valid the cycle after mem_req_o
- conflict_cnt_o  out  32  contention counter (see Optional Feature)

Behaviour:
- FSM states: IDLE, CORE_DONE, DMA_DONE. Register last_owner (CORE/DMA).
- IDLE:
  - Winner is chosen combinationally among active requests, round-robin: when both request, the owner opposite to last_owner wins.
  - The winner's fields drive mem_*; mem_req_o=1.
  - Next state is CORE_DONE or DMA_DONE; last_owner <= winner.
  - With no request: mem_req_o=0, stay in IDLE.
- CORE_DONE: no memory access issued; core_rd_o=mem_rd_i; next IDLE.
- DMA_DONE: no access issued; dma_rvalid_o=1, dma_rd_o=mem_rd_i; next IDLE.
- core_stall_o = core_req_i && state!=CORE_DONE. A core request that loses arbitration keeps stall high.
- dma_gnt_o=1 only in the IDLE cycle where DMA wins.
- Latency:
  - Uncontended access: 2 cycles, issue plus completion, for both requesters.
  - Contended core access: worst case 4 cycles.
  - No starvation under round-robin.
- mem_* fields are driven to 0 whenever mem_req_o=0.
- core_rd_o and dma_rd_o pass mem_rd_i unconditionally; validity is defined by the stall/rvalid rules above.
- Reset values:
  - state=IDLE, last_owner=DMA, so the core wins the first tie.
  - While rst_i=1, mem_req_o=0, dma_gnt_o=0, dma_rvalid_o=0.
  - core_stall_o follows core_req_i.
- Reset mid-access: the in-flight response is discarded. A write already issued to memory has taken effect. Requesters re-issue after reset.
- Simultaneous new requests in a DONE cycle are not accepted; they are arbitrated in the following IDLE cycle.
- Writes also pass through a DONE cycle. Write completion for the core is stall falling; for DMA it is an rvalid pulse.

Optional Feature:
- Macro: DATA_MEM_ARB_STAT_EN.
- Defined:
  - A 32-bit conflict_cnt_o increments by 1 in every IDLE cycle where core_req_i and dma_req_i are both high.
  - It saturates at 0xFFFF_FFFF and resets to 0.
- Undefined: conflict_cnt_o is tied to 0 and no counter register is synthesised.

Decomposition:
- Package data_arb_pkg:
  - arb_state_e (IDLE, CORE_DONE, DMA_DONE)
  - owner_e (OWNER_CORE, OWNER_DMA)
  - localparam for the counter width (32)
- Sub-module rr_arb2: a 2-requester round-robin picker. Inputs are req[1:0] and last_owner; output is a one-hot grant. It is combinational and instantiated once.

Test Plan:
- Core load only: core_req=1, we=0, addr=0x10 with memory word 0xDEADBEEF. Cycle0: stall=1, mem_req=1, mem_addr=0x10. Cycle1: stall=0, core_rd=0xDEADBEEF, mem_req=0.
- DMA write only: dma_req=1, addr=0x20, wd=0x12345678, be=4'b1111. Same cycle: dma_gnt=1, mem_we=1. Next cycle: dma_rvalid=1. A later core read of 0x20 returns 0x12345678.
- Simultaneous after reset: both requests high. Core wins (gnt=0, stall=1 then 0 after 2 cycles). DMA is granted in cycle 2 and rvalid in cycle 3.
- Back-to-back contention for 8 accesses each: grants alternate core/DMA. No core access waits more than 4 cycles. Reuse the existing stall assertions in contention-free windows.
- Reset asserted in CORE_DONE: the next cycle has state=IDLE, mem_req=0 during reset, and dma_rvalid=0. Core re-request completes normally.
- With DATA_MEM_ARB_STAT_EN: 5 contended IDLE cycles give conflict_cnt_o=5. Without the macro, conflict_cnt_o=0.
